// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver, Set-2 decoder and ASCII translator.
// Synchronizes and filters the raw PS/2 lines, assembles 11-bit frames,
// tracks shift/ctrl/caps lock and holds ascii_key non-zero while a key is down.
// Optional feature macro: PS2_PARITY_CHECK_EN (drop frames with bad parity).
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_key,
  output logic [7:0] scan_code,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       shift,
  output logic       ctrl,
  output logic       caps_lock
);

  localparam int              FCW       = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [31:0]     TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           filt_clk;
  logic [FCW-1:0] filt_cnt;
  logic           fall;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [31:0]    to_cnt;
  logic           parity_odd;
  logic           parity_ok;

  logic           ext, brk;
  logic           caps_held;
  logic [8:0]     held_code;
  logic [7:0]     xlat;

  // Two-stage synchronizers for both raw PS/2 lines (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign parity_odd = ^{shreg, par_bit};
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = parity_odd;
`else
  // Parity is still sampled so the frame shape is identical, but it never rejects.
  assign parity_ok = 1'b1 | parity_odd;
`endif

  // Frame assembly FSM with inactivity timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 32'd1;

      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall && !dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (fall) begin
              shreg   <= {dat_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                state <= PARITY;
            end
          end
          PARITY: begin
            if (fall) begin
              par_bit <= dat_s2;
              state   <= STOP;
            end
          end
          STOP: begin
            if (fall) begin
              state <= IDLE;
              if (dat_s2 && parity_ok) begin
                scan_code  <= shreg;
                byte_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [7:0] letter_lc(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] glyph(input logic [7:0] c, input logic sh);
    case (c)
      8'h16: return sh ? 8'h21 : 8'h31;
      8'h1E: return sh ? 8'h40 : 8'h32;
      8'h26: return sh ? 8'h23 : 8'h33;
      8'h25: return sh ? 8'h24 : 8'h34;
      8'h2E: return sh ? 8'h25 : 8'h35;
      8'h36: return sh ? 8'h5E : 8'h36;
      8'h3D: return sh ? 8'h26 : 8'h37;
      8'h3E: return sh ? 8'h2A : 8'h38;
      8'h46: return sh ? 8'h28 : 8'h39;
      8'h45: return sh ? 8'h29 : 8'h30;
      8'h0E: return sh ? 8'h7E : 8'h60;
      8'h4E: return sh ? 8'h5F : 8'h2D;
      8'h55: return sh ? 8'h2B : 8'h3D;
      8'h54: return sh ? 8'h7B : 8'h5B;
      8'h5B: return sh ? 8'h7D : 8'h5D;
      8'h5D: return sh ? 8'h7C : 8'h5C;
      8'h4C: return sh ? 8'h3A : 8'h3B;
      8'h52: return sh ? 8'h22 : 8'h27;
      8'h41: return sh ? 8'h3C : 8'h2C;
      8'h49: return sh ? 8'h3E : 8'h2E;
      8'h4A: return sh ? 8'h3F : 8'h2F;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ext_glyph(input logic [7:0] c);
    case (c)
      8'h5A: return 8'h0D;
      8'h4A: return 8'h2F;
      8'h75: return 8'h11;
      8'h72: return 8'h12;
      8'h6B: return 8'h13;
      8'h74: return 8'h14;
      default: return 8'h00;
    endcase
  endfunction

  // Translation of the current byte under the current modifier state.
  always_comb begin
    xlat = 8'h00;
    if (ext) begin
      xlat = ext_glyph(scan_code);
    end else if (letter_lc(scan_code) != 8'h00) begin
      if (ctrl)
        xlat = letter_lc(scan_code) - 8'h60;
      else if (shift ^ caps_lock)
        xlat = letter_lc(scan_code) - 8'h20;
      else
        xlat = letter_lc(scan_code);
    end else begin
      xlat = glyph(scan_code, shift);
    end
  end

  // Byte decoder: prefix flags, modifiers, and the held-key level on ascii_key.
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_key <= '0;
      held_code <= '0;
      shift     <= 1'b0;
      ctrl      <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else if (byte_valid) begin
      if (scan_code == 8'hE0) begin
        ext <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext && (scan_code == 8'h12 || scan_code == 8'h59)) begin
          shift <= ~brk;
        end else if (scan_code == 8'h14) begin
          ctrl <= ~brk;
        end else if (!ext && scan_code == 8'h58) begin
          if (brk) begin
            caps_held <= 1'b0;
          end else begin
            if (!caps_held)
              caps_lock <= ~caps_lock;
            caps_held <= 1'b1;
          end
        end else if (brk) begin
          // Releasing a key other than the most recent one leaves ascii_key alone.
          if ({ext, scan_code} == held_code)
            ascii_key <= 8'h00;
        end else if (xlat != 8'h00) begin
          ascii_key <= xlat;
          held_code <= {ext, scan_code};
        end
      end
    end
  end

endmodule
